// File: rtl/segway_drive_seq.sv
// Power/drive sequencer: soft-start ramp, motor enable, steering qualification and
// latched overspeed fault for the balance-math datapath.
module segway_drive_seq #(
    parameter int RAMP_DIV  = 16,
    parameter int FAULT_DIV = 4,
    parameter int STEER_DLY = 1024,
    parameter int OVS_CNT   = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       pwr_req,
    input  logic       steer_ok,
    input  logic       too_fast,
    input  logic       fault_clr,
    output logic [7:0] ss_tmr,
    output logic       pwr_up,
    output logic       en_steer,
    output logic       fault,
    output logic       ramp_done,
    output logic [2:0] state
);

    localparam int MAX_DIV = (RAMP_DIV > FAULT_DIV) ? RAMP_DIV : FAULT_DIV;
    localparam int PW      = $clog2(MAX_DIV + 1);
    localparam int SW      = $clog2(STEER_DLY + 1);
    localparam int OW      = $clog2(OVS_CNT + 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_RAMP  = 3'd1,
        S_RUN   = 3'd2,
        S_DOWN  = 3'd3,
        S_FAULT = 3'd4
    } state_t;

    state_t        cur_st;
    state_t        nxt_st;
    logic [PW-1:0] presc;
    logic [SW-1:0] steer_cnt;
    logic [OW-1:0] ovs_cnt;
    logic [PW-1:0] div_last;
    logic          ramping;
    logic          step;
    logic          ovs_hit;

    // Handshake-free block: every input is a level sampled on each rising clk edge.
    always_comb begin
        div_last = (cur_st == S_FAULT) ? PW'(FAULT_DIV - 1) : PW'(RAMP_DIV - 1);
        ramping  = (cur_st == S_RAMP) || (cur_st == S_DOWN) || (cur_st == S_FAULT);
        step     = ramping && (presc == div_last);
        // Hit on the edge that brings the run of too_fast samples up to OVS_CNT.
        ovs_hit  = too_fast && (ovs_cnt >= OW'(OVS_CNT - 1));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur_st <= S_IDLE;
        end else begin
            cur_st <= nxt_st;
        end
    end

    always_comb begin
        nxt_st = cur_st;
        case (cur_st)
            S_IDLE: begin
                if (pwr_req) nxt_st = S_RAMP;
            end
            S_RAMP: begin
                if (ovs_hit)                         nxt_st = S_FAULT;
                else if (!pwr_req)                   nxt_st = S_DOWN;
                else if (step && ss_tmr >= 8'd254)   nxt_st = S_RUN;
            end
            S_RUN: begin
                if (ovs_hit)       nxt_st = S_FAULT;
                else if (!pwr_req) nxt_st = S_DOWN;
            end
            S_DOWN: begin
                if (ovs_hit)                         nxt_st = S_FAULT;
                else if (pwr_req)                    nxt_st = S_RAMP;
                else if (step && ss_tmr <= 8'd1)     nxt_st = S_IDLE;
            end
            S_FAULT: begin
                if (ss_tmr == 8'd0 && fault_clr && !too_fast) nxt_st = S_IDLE;
            end
            default: nxt_st = S_IDLE;
        endcase
    end

    // Prescaler restarts on any state change so the first step lands DIV cycles in.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc     <= '0;
            ss_tmr    <= 8'd0;
            steer_cnt <= '0;
            ovs_cnt   <= '0;
        end else begin
            if ((nxt_st != cur_st) || !ramping || step) presc <= '0;
            else                                        presc <= presc + PW'(1);

            if (step) begin
                if (cur_st == S_RAMP) begin
                    if (ss_tmr != 8'd255) ss_tmr <= ss_tmr + 8'd1;
                end else if (ss_tmr != 8'd0) begin
                    ss_tmr <= ss_tmr - 8'd1;
                end
            end

            if (!too_fast)                   ovs_cnt <= '0;
            else if (ovs_cnt != OW'(OVS_CNT)) ovs_cnt <= ovs_cnt + OW'(1);

            if (cur_st != S_RUN || !steer_ok)    steer_cnt <= '0;
            else if (steer_cnt != SW'(STEER_DLY)) steer_cnt <= steer_cnt + SW'(1);
        end
    end

    // Outputs decode only registered state, so they change right after the edge.
    always_comb begin
        pwr_up    = (cur_st == S_RAMP) || (cur_st == S_RUN) || (cur_st == S_DOWN) ||
                    ((cur_st == S_FAULT) && (ss_tmr != 8'd0));
        fault     = (cur_st == S_FAULT);
        en_steer  = (cur_st == S_RUN) && (steer_cnt == SW'(STEER_DLY));
        ramp_done = (cur_st == S_RUN);
        state     = cur_st;
    end

endmodule

// File: tb/tb_segway_drive_seq.sv
// Randomized bench for segway_drive_seq: behavioural model feeds an expected-output
// queue, a negedge monitor pops and compares every cycle.
module tb_segway_drive_seq;

    localparam int RAMP_DIV  = 4;
    localparam int FAULT_DIV = 4;
    localparam int STEER_DLY = 8;
    localparam int OVS_CNT   = 4;

    logic       clk;
    logic       rst_n;
    logic       pwr_req;
    logic       steer_ok;
    logic       too_fast;
    logic       fault_clr;
    logic [7:0] ss_tmr;
    logic       pwr_up;
    logic       en_steer;
    logic       fault;
    logic       ramp_done;
    logic [2:0] state;

    int checks = 0;
    int errors = 0;

    logic [14:0] exp_q[$];

    // Model state: mode uses the documented debug encoding 0..4.
    int m_mode, m_level, m_tim, m_tf, m_steer;

    segway_drive_seq #(
        .RAMP_DIV(RAMP_DIV), .FAULT_DIV(FAULT_DIV),
        .STEER_DLY(STEER_DLY), .OVS_CNT(OVS_CNT)
    ) dut (
        .clk(clk), .rst_n(rst_n), .pwr_req(pwr_req), .steer_ok(steer_ok),
        .too_fast(too_fast), .fault_clr(fault_clr), .ss_tmr(ss_tmr),
        .pwr_up(pwr_up), .en_steer(en_steer), .fault(fault),
        .ramp_done(ramp_done), .state(state)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic model_reset();
        m_mode = 0; m_level = 0; m_tim = 0; m_tf = 0; m_steer = 0;
    endtask

    task automatic model_step(input logic p, input logic s, input logic t, input logic c);
        int  tm, dv, lvl, nm;
        bit  stp, hit, pu;
        m_tf = t ? m_tf + 1 : 0;
        hit  = (m_tf >= OVS_CNT) && (m_mode == 1 || m_mode == 2 || m_mode == 3);
        tm   = m_tim + 1;
        dv   = (m_mode == 4) ? FAULT_DIV : RAMP_DIV;
        stp  = (m_mode == 1 || m_mode == 3 || m_mode == 4) && (tm % dv == 0);
        lvl  = m_level;
        if (stp) begin
            if (m_mode == 1) lvl = (lvl < 255) ? lvl + 1 : 255;
            else             lvl = (lvl > 0) ? lvl - 1 : 0;
        end
        nm = m_mode;
        case (m_mode)
            0: if (p) nm = 1;
            1: if (hit) nm = 4; else if (!p) nm = 3; else if (stp && lvl == 255) nm = 2;
            2: if (hit) nm = 4; else if (!p) nm = 3;
            3: if (hit) nm = 4; else if (p) nm = 1; else if (stp && lvl == 0) nm = 0;
            4: if (m_level == 0 && c && !t) nm = 0;
            default: nm = 0;
        endcase
        m_steer = (m_mode == 2 && s) ? m_steer + 1 : 0;
        m_tim   = (nm != m_mode) ? 0 : tm;
        m_mode  = nm;
        m_level = lvl;
        pu = (nm == 1 || nm == 2 || nm == 3) || (nm == 4 && lvl > 0);
        exp_q.push_back({3'(nm), 8'(lvl), pu, (nm == 2 && m_steer >= STEER_DLY),
                         (nm == 4), (nm == 2)});
    endtask

    task automatic drive(input logic p, input logic s, input logic t, input logic c);
        pwr_req = p; steer_ok = s; too_fast = t; fault_clr = c;
        @(posedge clk);
        model_step(p, s, t, c);
        #1;
    endtask

    task automatic check_eq(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        logic [14:0] e;
        logic [14:0] a;
        if (rst_n && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            a = {state, ss_tmr, pwr_up, en_steer, fault, ramp_done};
            checks++;
            if (a !== e) begin
                errors++;
                $display("FAIL out_vec @%0t: got st=%0d ss=%0d pu=%b en=%b flt=%b rd=%b expected st=%0d ss=%0d pu=%b en=%b flt=%b rd=%b",
                         $time, a[14:12], a[11:4], a[3], a[2], a[1], a[0],
                         e[14:12], e[11:4], e[3], e[2], e[1], e[0]);
            end
        end
    end

    initial begin
        int n;
        model_reset();
        rst_n = 1'b0; pwr_req = 0; steer_ok = 0; too_fast = 0; fault_clr = 0;
        #1;
        check_eq("reset_outputs", {state, ss_tmr, pwr_up, en_steer, fault, ramp_done}, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Full ramp up: steer_ok random, nothing else active.
        n = 0;
        drive(1, 1'($urandom_range(0, 1)), 0, 0);
        n++;
        check_eq("pwr_up_after_req", pwr_up, 1);
        while (n < 1200 && !ramp_done) begin
            drive(1, 1'($urandom_range(0, 1)), 0, 1'($urandom_range(0, 1)));
            n++;
        end
        check_eq("ramp_cycles", n, 1 + 255 * RAMP_DIV);

        // Steering qualification, glitch, re-qualification.
        drive(1, 0, 0, 0);
        repeat (12) drive(1, 1, 0, 0);
        check_eq("en_steer_set", en_steer, 1);
        drive(1, 0, 0, 0);
        check_eq("en_steer_glitch", en_steer, 0);
        n = 0;
        while (n < 50 && !en_steer) begin
            drive(1, 1, 0, 0);
            n++;
        end
        check_eq("steer_requal", n, STEER_DLY);

        // Short overspeed bursts never qualify.
        for (int i = 0; i < 10; i++) begin
            repeat ($urandom_range(1, OVS_CNT - 1)) drive(1, 1, 1, 0);
            repeat ($urandom_range(1, 3)) drive(1, 1, 0, 0);
        end
        check_eq("no_fault_short", fault, 0);

        // Full ramp down.
        n = 0;
        drive(0, 1, 0, 0);
        n++;
        while (n < 1200 && state != 3'd0) begin
            drive(0, 1'($urandom_range(0, 1)), 0, 0);
            n++;
        end
        check_eq("down_cycles", n, 1 + 255 * RAMP_DIV);
        check_eq("idle_pwr_up", pwr_up, 0);

        // Mid-ramp bounce around ss_tmr=100.
        for (int i = 0; i < 500 && m_level < 100; i++) drive(1, 0, 0, 0);
        repeat ($urandom_range(5, 40)) drive(0, 0, 0, 0);
        repeat ($urandom_range(5, 40)) drive(1, 0, 0, 0);
        check_eq("bounce_no_jump", (ss_tmr > 80 && ss_tmr < 110) ? 1 : 0, 1);
        for (int i = 0; i < 1200 && !ramp_done; i++) drive(1, 0, 0, 0);

        // Qualified overspeed from RUN, clear blocked while too_fast persists.
        repeat (OVS_CNT - 1) drive(1, 1, 1, 0);
        drive(1, 1, 0, 0);
        check_eq("three_no_fault", fault, 0);
        repeat (OVS_CNT) drive(1, 1, 1, 0);
        check_eq("fault_entry", fault, 1);
        for (int i = 0; i < 1200 && m_level > 0; i++)
            drive(1'($urandom_range(0, 1)), 1, 1, 1);
        repeat (10) drive(1'($urandom_range(0, 1)), 1, 1, 1);
        check_eq("fault_held", state, 4);
        drive(1, 1, 0, 1);
        check_eq("fault_exit", {29'd0, state, fault}, 0);

        // Random phase.
        begin
            logic p;
            p = 1'b0;
            for (int i = 0; i < 3000; i++) begin
                if ($urandom_range(0, 63) == 0) p = ~p;
                drive(p, ($urandom_range(0, 7) != 0), ($urandom_range(0, 9) == 0),
                      ($urandom_range(0, 7) == 0));
            end
        end

        // Asynchronous reset in FAULT at ss_tmr=50.
        drive(0, 0, 0, 1);
        for (int i = 0; i < 1200 && m_mode != 0; i++) drive(0, 0, 0, 1);
        for (int i = 0; i < 400 && m_level < 60; i++) drive(1, 0, 0, 0);
        repeat (OVS_CNT) drive(1, 0, 1, 0);
        for (int i = 0; i < 400 && m_level > 50; i++) drive(0, 0, 1, 0);
        check_eq("pre_reset_fault", {24'd0, state, ss_tmr}, {24'd0, 3'd4, 8'd50});
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check_eq("async_reset", {state, ss_tmr, pwr_up, en_steer, fault, ramp_done}, 0);
        exp_q.delete();
        model_reset();
        pwr_req = 0; steer_ok = 0; too_fast = 0; fault_clr = 0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (5) drive(0, 0, 0, 0);
        check_eq("no_fault_memory", fault, 0);

        for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(negedge clk);
        check_eq("queue_drained", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
